// File: rtl/ext_mem_arbiter.sv
// Two-master round-robin arbiter and bus sequencer for the external peripheral
// register bank; follows the bank's ready handshake and aborts on timeout.
module ext_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_read,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_read,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  mem_cs,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  grant,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state, state_nx;
    logic                  last, last_nx;
    logic [CNT_W-1:0]      tcnt, tcnt_nx;
    logic                  grant_nx, cs_nx, read_nx, busy_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx, rdata0_nx, rdata1_nx;
    logic                  ack0_nx, ack1_nx, err0_nx, err1_nx;
    logic                  winner, finish, abort;

    // Next-state and next-output logic; every output is a register loaded from here.
    always_comb begin
        state_nx  = state;
        last_nx   = last;
        tcnt_nx   = tcnt;
        grant_nx  = grant;
        cs_nx     = mem_cs;
        read_nx   = mem_read;
        addr_nx   = mem_addr;
        wdata_nx  = mem_wdata;
        rdata0_nx = m0_rdata;
        rdata1_nx = m1_rdata;
        ack0_nx   = 1'b0;
        ack1_nx   = 1'b0;
        err0_nx   = 1'b0;
        err1_nx   = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        // On a tie the master that was not served last wins.
        winner    = (m0_req && m1_req) ? ~last : m1_req;

        case (state)
            S_IDLE: begin
                cs_nx = 1'b0;
                if (m0_req || m1_req) begin
                    grant_nx = winner;
                    read_nx  = winner ? m1_read  : m0_read;
                    addr_nx  = winner ? m1_addr  : m0_addr;
                    wdata_nx = winner ? m1_wdata : m0_wdata;
                    cs_nx    = 1'b1;
                    tcnt_nx  = '0;
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (tcnt == CNT_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_nx = tcnt + CNT_W'(1);
                    if (!mem_ready) begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    finish = 1'b1;
                    if (mem_read) begin
                        if (grant) begin
                            rdata1_nx = mem_rdata;
                        end else begin
                            rdata0_nx = mem_rdata;
                        end
                    end
                end else if (tcnt == CNT_LAST) begin
                    abort = 1'b1;
                end else begin
                    tcnt_nx = tcnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                cs_nx    = 1'b0;
                state_nx = S_IDLE;
            end
            default: begin
                cs_nx    = 1'b0;
                state_nx = S_IDLE;
            end
        endcase

        if (finish || abort) begin
            state_nx = S_DONE;
            cs_nx    = 1'b0;
            last_nx  = grant;
            ack0_nx  = ~grant;
            ack1_nx  = grant;
            err0_nx  = abort & ~grant;
            err1_nx  = abort & grant;
        end
        // An aborted transaction returns zero data to its master.
        if (abort) begin
            if (grant) begin
                rdata1_nx = '0;
            end else begin
                rdata0_nx = '0;
            end
        end

        busy_nx = (state_nx != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            tcnt      <= '0;
            grant     <= 1'b0;
            mem_cs    <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            tcnt      <= tcnt_nx;
            grant     <= grant_nx;
            mem_cs    <= cs_nx;
            mem_read  <= read_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            m0_rdata  <= rdata0_nx;
            m1_rdata  <= rdata1_nx;
            m0_ack    <= ack0_nx;
            m1_ack    <= ack1_nx;
            m0_err    <= err0_nx;
            m1_err    <= err1_nx;
            busy      <= busy_nx;
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: behavioural bank, transaction-level
// reference model (memory array, round-robin pointer, fixed latencies).
module tb_ext_mem_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_read = 1'b0, m1_req = 1'b0, m1_read = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_cs, mem_read, mem_ready, grant, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    ext_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_read(m0_read), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_read(m1_read), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_cs(mem_cs), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bank: latches cs, drops ready for one cycle, performs the access, then idles a cycle.
    logic [15:0] bank_mem [16];
    int          bank_st;
    bit          bank_dead = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            bank_st   <= 0;
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            for (int i = 0; i < 16; i++) bank_mem[i] <= '0;
        end else begin
            case (bank_st)
                0: if (mem_cs && !bank_dead) begin
                    mem_ready <= 1'b0;
                    bank_st   <= 1;
                end
                1: begin
                    if (mem_read) mem_rdata <= bank_mem[mem_addr[3:0]];
                    else          bank_mem[mem_addr[3:0]] <= mem_wdata;
                    mem_ready <= 1'b1;
                    bank_st   <= 2;
                end
                default: bank_st <= 0;
            endcase
        end
    end

    int n_pass = 0;
    int n_total = 0;

    // Stimulus for one round of requests.
    bit          s_en [2];
    bit          s_rd [2];
    logic [15:0] s_addr [2];
    logic [15:0] s_wdata [2];

    // Reference model state and expectations.
    logic [15:0] m_mem [16];
    logic [15:0] m_rd [2];
    bit          m_last;
    int          e_first, e_cs;
    int          e_lat [2];
    logic [15:0] e_rdata [2];
    logic        e_err [2];

    // Observed results.
    int          r_first, r_cs;
    int          r_lat [2];
    int          r_ackcnt [2];
    logic [15:0] r_rdata [2];
    logic        r_err [2];
    logic        r_grant [2];
    bit          r_both, r_hang;

    task automatic model_reset();
        m_last = 1'b1;
        m_rd[0] = '0;
        m_rd[1] = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
    endtask

    // Serve the enabled masters in round-robin order and predict each outcome.
    task automatic model_run(input bit dead);
        int order [2];
        int n;
        int m;
        if (s_en[0] && s_en[1]) begin
            e_first = m_last ? 0 : 1;
            n = 2;
        end else begin
            e_first = s_en[0] ? 0 : 1;
            n = 1;
        end
        order[0] = e_first;
        order[1] = 1 - e_first;
        e_cs = 0;
        for (int k = 0; k < n; k++) begin
            m = order[k];
            e_lat[m] = dead ? (TO + 1) + k * (TO + 2) : 4 + 5 * k;
            e_cs += dead ? TO : 3;
            if (dead) begin
                m_rd[m]  = '0;
                e_err[m] = 1'b1;
            end else begin
                e_err[m] = 1'b0;
                if (s_rd[m]) m_rd[m] = m_mem[s_addr[m][3:0]];
                else         m_mem[s_addr[m][3:0]] = s_wdata[m];
            end
            e_rdata[m] = m_rd[m];
            m_last = (m == 1);
        end
    endtask

    // Raise the enabled requests together and collect acks within a cycle budget.
    task automatic run_ops();
        int  cyc;
        bit  done0, done1;
        r_first = -1; r_cs = 0; r_both = 1'b0;
        for (int m = 0; m < 2; m++) begin
            r_lat[m] = -1; r_ackcnt[m] = 0; r_rdata[m] = 'x; r_err[m] = 1'bx; r_grant[m] = 1'bx;
        end
        @(negedge clk);
        m0_req = s_en[0]; m0_read = s_rd[0]; m0_addr = s_addr[0]; m0_wdata = s_wdata[0];
        m1_req = s_en[1]; m1_read = s_rd[1]; m1_addr = s_addr[1]; m1_wdata = s_wdata[1];
        done0 = !s_en[0];
        done1 = !s_en[1];
        cyc = 0;
        while (!(done0 && done1) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_cs) r_cs++;
            if (m0_ack && m1_ack) r_both = 1'b1;
            if (m0_ack) begin
                r_ackcnt[0]++;
                if (!done0) begin
                    r_lat[0] = cyc; r_rdata[0] = m0_rdata; r_err[0] = m0_err; r_grant[0] = grant;
                    if (r_first < 0) r_first = 0;
                end
                done0 = 1'b1;
                m0_req = 1'b0;
            end
            if (m1_ack) begin
                r_ackcnt[1]++;
                if (!done1) begin
                    r_lat[1] = cyc; r_rdata[1] = m1_rdata; r_err[1] = m1_err; r_grant[1] = grant;
                    if (r_first < 0) r_first = 1;
                end
                done1 = 1'b1;
                m1_req = 1'b0;
            end
        end
        r_hang = !(done0 && done1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_ack) r_ackcnt[0]++;
            if (m1_ack) r_ackcnt[1]++;
        end
    endtask

    task automatic set_op(input int m, input bit en, input bit rd, input logic [15:0] a, input logic [15:0] w);
        s_en[m] = en; s_rd[m] = rd; s_addr[m] = a; s_wdata[m] = w;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({mem_cs, mem_read, busy, grant, m0_ack, m1_ack, m0_err, m1_err} !== 8'h00)
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {mem_cs, mem_read, busy, grant, m0_ack, m1_ack, m0_err, m1_err});
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata} !== 32'h0)
            $display("FAIL reset_bus: got %h expected 00000000", {mem_addr, mem_wdata});
        else n_pass++;
        n_total++;
        if ({m0_rdata, m1_rdata} !== 32'h0)
            $display("FAIL reset_rdata: got %h expected 00000000", {m0_rdata, m1_rdata});
        else n_pass++;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_write();
        set_op(0, 1, 0, 16'h0008, 16'hA5A5);
        set_op(1, 0, 0, 16'h0000, 16'h0000);
        model_run(0);
        run_ops();
        n_total++;
        if (r_lat[0] !== 4) $display("FAIL write_ack_latency: got %0d expected 4", r_lat[0]);
        else n_pass++;
        n_total++;
        if (r_cs !== 3) $display("FAIL write_cs_cycles: got %0d expected 3", r_cs);
        else n_pass++;
        n_total++;
        if (bank_mem[8] !== 16'hA5A5) $display("FAIL write_bank_word8: got %h expected a5a5", bank_mem[8]);
        else n_pass++;
        n_total++;
        if (r_ackcnt[0] !== 1 || r_ackcnt[1] !== 0)
            $display("FAIL write_ack_counts: got m0=%0d m1=%0d expected m0=1 m1=0", r_ackcnt[0], r_ackcnt[1]);
        else n_pass++;
    endtask

    task automatic test_single_read();
        set_op(0, 1, 0, 16'h0007, 16'h1234);
        set_op(1, 0, 0, 16'h0000, 16'h0000);
        model_run(0);
        run_ops();
        set_op(0, 0, 0, 16'h0000, 16'h0000);
        set_op(1, 1, 1, 16'h0007, 16'h0000);
        model_run(0);
        run_ops();
        n_total++;
        if (r_lat[1] !== 4) $display("FAIL read_ack_latency: got %0d expected 4", r_lat[1]);
        else n_pass++;
        n_total++;
        if (r_rdata[1] !== 16'h1234) $display("FAIL read_rdata: got %h expected 1234", r_rdata[1]);
        else n_pass++;
        n_total++;
        if (r_err[1] !== 1'b0 || r_ackcnt[0] !== 0)
            $display("FAIL read_err_other_ack: got err=%b m0acks=%0d expected err=0 m0acks=0", r_err[1], r_ackcnt[0]);
        else n_pass++;
    endtask

    task automatic test_contention();
        for (int t = 0; t < 2; t++) begin
            for (int m = 0; m < 2; m++)
                set_op(m, 1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            model_run(0);
            run_ops();
            n_total++;
            if (r_hang || r_both) $display("FAIL contention_complete: got hang=%b both_ack=%b expected 0 0", r_hang, r_both);
            else n_pass++;
            n_total++;
            if (r_first !== e_first) $display("FAIL contention_order: got first=%0d expected %0d", r_first, e_first);
            else n_pass++;
            n_total++;
            if (r_cs !== e_cs) $display("FAIL contention_cs_cycles: got %0d expected %0d", r_cs, e_cs);
            else n_pass++;
            for (int m = 0; m < 2; m++) begin
                n_total++;
                if (r_lat[m] !== e_lat[m] || r_ackcnt[m] !== 1 || r_grant[m] !== 1'(m))
                    $display("FAIL contention_m%0d_ack: got lat=%0d acks=%0d grant=%b expected lat=%0d acks=1 grant=%0d",
                             m, r_lat[m], r_ackcnt[m], r_grant[m], e_lat[m], m);
                else n_pass++;
                n_total++;
                if (r_rdata[m] !== e_rdata[m]) $display("FAIL contention_m%0d_rdata: got %h expected %h", m, r_rdata[m], e_rdata[m]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        set_op(0, 1, 1, 16'h0007, 16'h0000);
        set_op(1, 0, 0, 16'h0000, 16'h0000);
        model_run(0);
        run_ops();
        n_total++;
        if (r_rdata[0] !== e_rdata[0]) $display("FAIL timeout_preread: got %h expected %h", r_rdata[0], e_rdata[0]);
        else n_pass++;
        bank_dead = 1'b1;
        model_run(1);
        run_ops();
        bank_dead = 1'b0;
        n_total++;
        if (r_lat[0] !== TO + 1) $display("FAIL timeout_ack_latency: got %0d expected %0d", r_lat[0], TO + 1);
        else n_pass++;
        n_total++;
        if (r_err[0] !== 1'b1 || r_rdata[0] !== 16'h0000)
            $display("FAIL timeout_err_rdata: got err=%b rdata=%h expected err=1 rdata=0000", r_err[0], r_rdata[0]);
        else n_pass++;
        n_total++;
        if (r_cs !== TO) $display("FAIL timeout_cs_cycles: got %0d expected %0d", r_cs, TO);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || r_ackcnt[0] !== 1)
            $display("FAIL timeout_idle: got busy=%b acks=%0d expected busy=0 acks=1", busy, r_ackcnt[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acks;
        @(negedge clk);
        m0_req = 1'b1; m0_read = 1'b1; m0_addr = 16'h0003;
        repeat (3) @(negedge clk);
        n_total++;
        if (mem_cs !== 1'b1 || busy !== 1'b1)
            $display("FAIL rstmid_in_flight: got cs=%b busy=%b expected 1 1", mem_cs, busy);
        else n_pass++;
        reset = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_cs, busy, m0_ack} !== 3'b000)
            $display("FAIL rstmid_abort: got cs/busy/ack=%b expected 000", {mem_cs, busy, m0_ack});
        else n_pass++;
        reset = 1'b0;
        model_reset();
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        n_total++;
        if (acks !== 0) $display("FAIL rstmid_no_ack: got %0d acks expected 0", acks);
        else n_pass++;
        set_op(0, 0, 0, 16'h0000, 16'h0000);
        set_op(1, 1, 0, 16'h0005, 16'hBEEF);
        model_run(0);
        run_ops();
        set_op(1, 1, 1, 16'h0005, 16'h0000);
        model_run(0);
        run_ops();
        n_total++;
        if (r_lat[1] !== 4 || r_rdata[1] !== 16'hBEEF || r_err[1] !== 1'b0)
            $display("FAIL rstmid_recover: got lat=%0d rdata=%h err=%b expected lat=4 rdata=beef err=0",
                     r_lat[1], r_rdata[1], r_err[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] wd [3];
        int          ack_cyc [3];
        int          k, cyc;
        for (int i = 0; i < 3; i++) wd[i] = 16'($urandom);
        @(negedge clk);
        m0_req = 1'b1; m0_read = 1'b0; m0_addr = 16'h000A; m0_wdata = wd[0];
        k = 0; cyc = 0;
        while (k < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m0_ack) begin
                ack_cyc[k] = cyc;
                k++;
                if (k < 3) begin
                    m0_addr = 16'(16'h000A + k);
                    m0_wdata = wd[k];
                end else m0_req = 1'b0;
            end
        end
        m0_req = 1'b0;
        for (int i = 0; i < 3; i++) m_mem[10 + i] = wd[i];
        m_last = 1'b0;
        n_total++;
        if (k !== 3) $display("FAIL b2b_ack_count: got %0d expected 3", k);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (k > i && ack_cyc[i] !== 4 + 5 * i)
                $display("FAIL b2b_ack%0d_cycle: got %0d expected %0d", i, ack_cyc[i], 4 + 5 * i);
            else if (k > i) n_pass++;
            else $display("FAIL b2b_ack%0d_cycle: got none expected %0d", i, 4 + 5 * i);
            n_total++;
            if (bank_mem[10 + i] !== m_mem[10 + i])
                $display("FAIL b2b_word%0d: got %h expected %h", 10 + i, bank_mem[10 + i], m_mem[10 + i]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int pat;
        for (int t = 0; t < 12; t++) begin
            pat = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++)
                set_op(m, 1'((pat >> m) & 1), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            model_run(0);
            run_ops();
            n_total++;
            if (r_hang || r_both) $display("FAIL rand%0d_complete: got hang=%b both_ack=%b expected 0 0", t, r_hang, r_both);
            else n_pass++;
            n_total++;
            if (r_first !== e_first) $display("FAIL rand%0d_order: got first=%0d expected %0d", t, r_first, e_first);
            else n_pass++;
            for (int m = 0; m < 2; m++) begin
                n_total++;
                if (!s_en[m] && r_ackcnt[m] !== 0)
                    $display("FAIL rand%0d_m%0d_spurious: got %0d acks expected 0", t, m, r_ackcnt[m]);
                else if (s_en[m] && (r_lat[m] !== e_lat[m] || r_ackcnt[m] !== 1 || r_err[m] !== e_err[m] ||
                                     r_rdata[m] !== e_rdata[m]))
                    $display("FAIL rand%0d_m%0d: got lat=%0d acks=%0d err=%b rdata=%h expected lat=%0d acks=1 err=%b rdata=%h",
                             t, m, r_lat[m], r_ackcnt[m], r_err[m], r_rdata[m], e_lat[m], e_err[m], e_rdata[m]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_single_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
